sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
Reader side of the sprite colour ROMs.
- On start, walks every pixel of one SPRITE_W x SPRITE_H sprite, drives row/col addresses into a ROM and consumes its 12-bit colour_data.
- Emits framebuffer write requests at screen position (x0+col, y0+row).
- Drops pixels equal to KEY_COLOR; honours framebuffer backpressure.
- Sits between the sprite ROMs and the framebuffer/line-buffer write port.

Parameters:
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels.
- COL_W, 4, ROM column address width (2^COL_W >= SPRITE_W).
- ROW_W, 4, ROM row address width (2^ROW_W >= SPRITE_H).
- X_W, 10, framebuffer x coordinate width.
- Y_W, 9, framebuffer y coordinate width.
- KEY_COLOR, 12'hF0F, transparent colour; never written.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- x0  in  X_W  sprite origin x; latched on accepted start.
- y0  in  Y_W  sprite origin y; latched on accepted start.
- busy  out  1  high from cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse when the last pixel has retired.
- rom_row  out  ROW_W  ROM row address.
- rom_col  out  COL_W  ROM column address.
- rom_color  in  12  ROM data; valid one cycle after its address is presented (ROM registers the address).
- wr_en  out  1  write request.
- wr_x  out  X_W  write x.
- wr_y  out  Y_W  write y.
- wr_color  out  12  write colour.
- wr_ready  in  1  framebuffer accepts; a write transfers when wr_en and wr_ready are both high.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
  - Reset values: FSM=IDLE; busy=0, done=0, wr_en=0; rom_row=0, rom_col=0; wr_x=0, wr_y=0, wr_color=0; counters and stage-1 valid cleared.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: on start=1, latch x0/y0, clear counters (r=0, c=0), go to FETCH. start is ignored in all other states.
  - FETCH: present address (r,c) each cycle. An address advances only when not stalled. c increments; at c=SPRITE_W-1, c wraps to 0 and r increments. After issuing (SPRITE_H-1, SPRITE_W-1), go to DRAIN.
  - DRAIN: wait until stage 1 retires (valid=0, or its write has transferred), then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then IDLE. A start arriving in DONE is ignored.
- Pipeline: stage 0 issues the address. Stage 1 holds valid, r1, c1 and is fed by rom_color one cycle later. Start-to-first-wr_en latency is 2 cycles: one for the start register, one for the ROM.
- Write generation, combinational from stage 1:
  - wr_en = valid1 && (rom_color != KEY_COLOR).
  - wr_x = x0_l + c1; wr_y = y0_l + r1.
  - Both sums are truncated to X_W/Y_W; wrap-around is permitted and not flagged.
  - wr_color = rom_color.
- Key pixels retire from stage 1 in one cycle without asserting wr_en.
- Stall: stall = wr_en && !wr_ready.
  - Counters and stage 1 hold.
  - rom_row/rom_col are muxed to r1/c1, so the ROM re-presents the same pixel and wr_color stays stable.
  - wr_en, wr_x, wr_y and wr_color must not change while stalled.
- Throughput: 1 pixel/cycle with wr_ready=1. Total run = SPRITE_W*SPRITE_H + 2 cycles from start to done.
- Reset mid-operation returns to the reset state immediately. No partial done pulse.

Optional Feature:
- Macro: SPRITE_BLITTER_FLIP_EN.
- Defined: adds input flip_h (1 bit), latched on accepted start. When the latched value is 1, the ROM column is SPRITE_W-1-c, while wr_x still uses x0+c, so the sprite is mirrored horizontally. The stall mux applies the same mirroring.
- Undefined: port absent, no mirroring logic.

Test Plan:
- Fully opaque ROM (all 12'h0F0), x0=100, y0=50, wr_ready=1 -> 256 writes.
  - First write (100,50) on cycle 2 after start; last write (115,65).
  - done pulses once at cycle 258.
- ROM returns KEY_COLOR where col is even -> exactly 128 writes, all with odd x offsets; done timing unchanged.
- wr_ready low for 3 cycles on the 5th write -> wr_en/wr_x/wr_y/wr_color are held constant for 3 cycles.
  - rom_row/rom_col equal the stalled pixel's address during the stall.
  - No pixel is lost or duplicated; 256 writes in total.
- x0=1020, y0=510 -> wr_x wraps to 0..11 and wr_y wraps to 0..13 with 10/9-bit truncation.
- rst_n asserted mid-FETCH (pixel 40) -> all outputs return to reset values immediately and no done pulse.
  - A new start after release restarts at (0,0).
- start pulsed while busy, and again in DONE -> ignored; exactly one run and one done.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H sprite ROM and emits framebuffer writes, skipping KEY_COLOR.
// Optional horizontal mirroring is enabled with the SPRITE_BLITTER_FLIP_EN macro (adds input flip_h).
module sprite_blitter #(
  parameter int          SPRITE_W  = 16,
  parameter int          SPRITE_H  = 16,
  parameter int          COL_W     = 4,
  parameter int          ROW_W     = 4,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
`ifdef SPRITE_BLITTER_FLIP_EN
  input  logic             flip_h,
`endif
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [11:0]      rom_color,
  output logic             wr_en,
  output logic [X_W-1:0]   wr_x,
  output logic [Y_W-1:0]   wr_y,
  output logic [11:0]      wr_color,
  input  logic             wr_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

  state_t           state_r, state_s;
  logic [ROW_W-1:0] row_r, row1_r, addr_row_s;
  logic [COL_W-1:0] col_r, col1_r, addr_col_s;
  logic [X_W-1:0]   x0_r;
  logic [Y_W-1:0]   y0_r;
  logic             valid_r;
  logic             stall_s;
  logic             issue_s;
  logic             last_s;
  logic             col_end_s;
  logic             accept_s;

  assign accept_s  = (state_r == ST_IDLE) && start;
  assign col_end_s = (col_r == COL_W'(SPRITE_W - 1));
  assign last_s    = col_end_s && (row_r == ROW_W'(SPRITE_H - 1));
  assign stall_s   = wr_en && !wr_ready;
  assign issue_s   = (state_r == ST_FETCH) && !stall_s;

  assign wr_en    = valid_r && (rom_color != KEY_COLOR);
  assign wr_x     = x0_r + X_W'(col1_r);
  assign wr_y     = y0_r + Y_W'(row1_r);
  assign wr_color = valid_r ? rom_color : 12'h000;
  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);

  // While stalled the ROM re-reads the pending pixel so rom_color stays put.
  assign addr_row_s = stall_s ? row1_r : row_r;
  assign addr_col_s = stall_s ? col1_r : col_r;
  assign rom_row    = addr_row_s;

`ifdef SPRITE_BLITTER_FLIP_EN
  logic flip_r;

  // Mirror flag captured with the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_r <= 1'b0;
    end else if (accept_s) begin
      flip_r <= flip_h;
    end
  end

  assign rom_col = flip_r ? (COL_W'(SPRITE_W - 1) - addr_col_s) : addr_col_s;
`else
  assign rom_col = addr_col_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_FETCH;
        else       state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (issue_s && last_s) state_s = ST_DRAIN;
        else                   state_s = ST_FETCH;
      end
      ST_DRAIN: begin
        if (!stall_s) state_s = ST_DONE;
        else          state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Origin latch and row/column walk; counters return to zero after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= '0;
      col_r <= '0;
      x0_r  <= '0;
      y0_r  <= '0;
    end else if (accept_s) begin
      row_r <= '0;
      col_r <= '0;
      x0_r  <= x0;
      y0_r  <= y0;
    end else if (issue_s) begin
      if (col_end_s) begin
        col_r <= '0;
        row_r <= last_s ? '0 : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Stage 1: pixel address paired with the ROM data arriving one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      row1_r  <= '0;
      col1_r  <= '0;
    end else if (!stall_s) begin
      valid_r <= issue_s;
      if (issue_s) begin
        row1_r <= row_r;
        col1_r <= col_r;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a registered behavioural ROM.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  x0 = 10'd0;
  logic [8:0]  y0 = 9'd0;
  logic        flip_h = 1'b0;
  logic        busy, done, wr_en, wr_ready = 1'b1;
  logic [3:0]  rom_row, rom_col;
  logic [11:0] rom_color, rom_q = 12'h000;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_color;

  int total = 0;
  int bad = 0;
  int mode = 0;

  int r_nwr, r_first, r_done_cyc, r_ndone, r_coord_bad, r_hold_bad, r_busy_bad, r_stalls;
  logic [9:0] r_last_x;
  logic [8:0] r_last_y;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0),
`ifdef SPRITE_BLITTER_FLIP_EN
    .flip_h(flip_h),
`endif
    .busy(busy), .done(done), .rom_row(rom_row), .rom_col(rom_col),
    .rom_color(rom_color), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_ready(wr_ready)
  );

  function automatic logic [11:0] rom_fn(input int m, input logic [3:0] row, input logic [3:0] col);
    case (m)
      1: rom_fn = (col[0] == 1'b0) ? 12'hF0F : {4'h1, row, col};
      2: rom_fn = {4'hA, row, col};
      default: rom_fn = 12'h0F0;
    endcase
  endfunction

  always @(posedge clk) rom_q <= rom_fn(mode, rom_row, rom_col);
  assign rom_color = rom_q;

  task automatic pulse_start(input logic [9:0] ax, input logic [8:0] ay);
    @(posedge clk);
    #1;
    x0 = ax;
    y0 = ay;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One full sprite run against an independent pixel-order model.
  task automatic run(input logic [9:0] ax, input logic [8:0] ay, input int amode,
                     input int stall_idx, input bit extra_start);
    int pix;
    int cyc;
    logic [3:0] er, ec;
    logic [9:0] ex;
    logic [8:0] ey;
    logic exp_busy;
    mode = amode;
    r_nwr = 0; r_first = -1; r_done_cyc = -1; r_ndone = 0;
    r_coord_bad = 0; r_hold_bad = 0; r_busy_bad = 0; r_stalls = 0;
    r_last_x = 10'd0; r_last_y = 9'd0;
    pix = 0;
    pulse_start(ax, ay);
    for (cyc = 1; cyc <= 280; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        r_ndone++;
        r_done_cyc = cyc;
      end
      exp_busy = (r_ndone == 0) || (cyc == r_done_cyc);
      if (busy !== exp_busy) r_busy_bad++;
      start = extra_start && (cyc == 10 || done === 1'b1);
      if (wr_en === 1'b1) begin
        while (pix < 256 && rom_fn(amode, 4'(pix / 16), 4'(pix % 16)) == 12'hF0F) pix++;
        er = 4'(pix / 16);
        ec = 4'(pix % 16);
        ex = ax + 10'(ec);
        ey = ay + 9'(er);
        if (pix >= 256 || wr_x !== ex || wr_y !== ey || wr_color !== rom_fn(amode, er, ec))
          r_coord_bad++;
        if (r_first < 0) r_first = cyc;
        if (r_nwr == stall_idx && r_stalls < 3) begin
          wr_ready = 1'b0;
          r_stalls++;
          #1;
          if (rom_row !== er || rom_col !== ec || wr_en !== 1'b1) r_hold_bad++;
        end else begin
          wr_ready = 1'b1;
          r_nwr++;
          pix++;
          r_last_x = wr_x;
          r_last_y = wr_y;
        end
      end else begin
        wr_ready = 1'b1;
      end
    end
    start = 1'b0;
    wr_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    total++; if ({rom_row, rom_col} !== 8'h00) begin bad++; $display("FAIL reset_rom_addr got=%h want=00", {rom_row, rom_col}); end
    total++; if ({wr_x, wr_y, wr_color} !== 31'd0) begin bad++; $display("FAIL reset_wr_bus got=%h want=0", {wr_x, wr_y, wr_color}); end
    rst_n = 1'b1;
  endtask

  task automatic test_opaque;
    run(10'd100, 9'd50, 0, -1, 1'b0);
    total++; if (r_nwr !== 256) begin bad++; $display("FAIL opaque_count got=%0d want=256", r_nwr); end
    total++; if (r_first !== 2) begin bad++; $display("FAIL opaque_first_cycle got=%0d want=2", r_first); end
    total++; if (r_done_cyc !== 258 || r_ndone !== 1) begin bad++; $display("FAIL opaque_done got=cyc%0d x%0d want=cyc258 x1", r_done_cyc, r_ndone); end
    total++; if (r_coord_bad !== 0) begin bad++; $display("FAIL opaque_pixels got=%0d bad want=0", r_coord_bad); end
    total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL opaque_busy got=%0d bad want=0", r_busy_bad); end
    total++; if (r_last_x !== 10'd115 || r_last_y !== 9'd65) begin bad++; $display("FAIL opaque_last got=(%0d,%0d) want=(115,65)", r_last_x, r_last_y); end
  endtask

  task automatic test_keyed;
    run(10'd100, 9'd50, 1, -1, 1'b0);
    total++; if (r_nwr !== 128) begin bad++; $display("FAIL keyed_count got=%0d want=128", r_nwr); end
    total++; if (r_coord_bad !== 0) begin bad++; $display("FAIL keyed_pixels got=%0d bad want=0", r_coord_bad); end
    total++; if (r_done_cyc !== 258 || r_ndone !== 1) begin bad++; $display("FAIL keyed_done got=cyc%0d x%0d want=cyc258 x1", r_done_cyc, r_ndone); end
    total++; if (r_last_x !== 10'd115 || r_last_y !== 9'd65) begin bad++; $display("FAIL keyed_last got=(%0d,%0d) want=(115,65)", r_last_x, r_last_y); end
  endtask

  task automatic test_stall;
    run(10'd200, 9'd20, 2, 4, 1'b0);
    total++; if (r_stalls !== 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", r_stalls); end
    total++; if (r_hold_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d bad want=0", r_hold_bad); end
    total++; if (r_coord_bad !== 0) begin bad++; $display("FAIL stall_pixels got=%0d bad want=0", r_coord_bad); end
    total++; if (r_nwr !== 256) begin bad++; $display("FAIL stall_count got=%0d want=256", r_nwr); end
    total++; if (r_done_cyc !== 261) begin bad++; $display("FAIL stall_done got=%0d want=261", r_done_cyc); end
  endtask

  task automatic test_wrap;
    run(10'd1020, 9'd510, 2, -1, 1'b0);
    total++; if (r_coord_bad !== 0) begin bad++; $display("FAIL wrap_pixels got=%0d bad want=0", r_coord_bad); end
    total++; if (r_last_x !== 10'd11 || r_last_y !== 9'd13) begin bad++; $display("FAIL wrap_last got=(%0d,%0d) want=(11,13)", r_last_x, r_last_y); end
  endtask

  task automatic test_midrun_reset;
    int n;
    int k;
    int dseen;
    mode = 0;
    n = 0;
    pulse_start(10'd5, 9'd6);
    for (k = 0; k < 100 && n < 40; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1) n++;
    end
    total++; if (n !== 40) begin bad++; $display("FAIL midrun_reach got=%0d want=40", n); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, wr_en} !== 3'b000) begin bad++; $display("FAIL midrun_ctrl got=%b want=000", {busy, done, wr_en}); end
    total++; if ({rom_row, rom_col} !== 8'h00 || {wr_x, wr_y, wr_color} !== 31'd0) begin bad++; $display("FAIL midrun_bus got=%h/%h want=0/0", {rom_row, rom_col}, {wr_x, wr_y, wr_color}); end
    dseen = 0;
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) dseen++;
    end
    rst_n = 1'b1;
    for (k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dseen++;
    end
    total++; if (dseen !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", dseen); end
    run(10'd0, 9'd0, 2, -1, 1'b0);
    total++; if (r_first !== 2 || r_coord_bad !== 0) begin bad++; $display("FAIL midrun_restart got=first%0d bad%0d want=first2 bad0", r_first, r_coord_bad); end
  endtask

  task automatic test_ignore_start;
    run(10'd300, 9'd100, 0, -1, 1'b1);
    total++; if (r_ndone !== 1 || r_done_cyc !== 258) begin bad++; $display("FAIL ignore_done got=x%0d cyc%0d want=x1 cyc258", r_ndone, r_done_cyc); end
    total++; if (r_nwr !== 256 || r_coord_bad !== 0) begin bad++; $display("FAIL ignore_writes got=%0d bad%0d want=256 bad0", r_nwr, r_coord_bad); end
    total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL ignore_busy got=%0d bad want=0", r_busy_bad); end
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_keyed();
    test_stall();
    test_wrap();
    test_midrun_reset();
    test_ignore_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
